// File: rtl/zbt_display_reader.sv
// Display-side ZBT reader: prefetches packed 4-pixel words one group ahead of the
// raster and emits one pixel per clock, one cycle behind hcount/vcount.
module zbt_display_reader #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int H_TOTAL  = 800,
  parameter int V_TOTAL  = 525
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [10:0] hcount,
  input  logic [9:0]  vcount,
  input  logic        bank_sel,
  output logic [18:0] zbtr_read_addr,
  input  logic [35:0] zbtr_read_data,
  output logic [7:0]  px_out,
  output logic        px_valid,
  output logic        frame_start
);

  logic        bank_q, bank_d;
  logic [18:0] addr_q, addr_d;
  logic [35:0] word_q, word_d;
  logic [7:0]  px_q, px_d;
  logic        px_valid_q, px_valid_d;
  logic        frame_start_q, frame_start_d;

  logic        fetch_edge, frame_edge, target_active, active;
  logic [11:0] tcol_raw, tcol;
  logic [9:0]  tline;
  logic [7:0]  sel_byte;

  always_comb begin
    fetch_edge = (hcount[1:0] == 2'b11);
    frame_edge = (hcount == 11'(H_TOTAL - 5)) && (vcount == 10'(V_TOTAL - 1));

    // Target column five ahead of the raster; past the line end it wraps onto the next line.
    tcol_raw = {1'b0, hcount} + 12'd5;
    if (tcol_raw >= 12'(H_TOTAL)) begin
      tcol  = tcol_raw - 12'(H_TOTAL);
      tline = (vcount == 10'(V_TOTAL - 1)) ? 10'd0 : vcount + 10'd1;
    end else begin
      tcol  = tcol_raw;
      tline = vcount;
    end
    target_active = (tcol < 12'(H_ACTIVE)) && ({1'b0, tline} < 11'(V_ACTIVE));

    // The frame-boundary fetch already uses the newly latched bank.
    bank_d = frame_edge ? bank_sel : bank_q;
    addr_d = (fetch_edge && target_active) ? {bank_d, tline, tcol[9:2]} : addr_q;
    word_d = fetch_edge ? zbtr_read_data : word_q;

    case (hcount[1:0])
      2'd0:    sel_byte = word_q[31:24];
      2'd1:    sel_byte = word_q[23:16];
      2'd2:    sel_byte = word_q[15:8];
      default: sel_byte = word_q[7:0];
    endcase

    active        = ({1'b0, hcount} < 12'(H_ACTIVE)) && ({1'b0, vcount} < 11'(V_ACTIVE));
    px_d          = active ? sel_byte : 8'd0;
    px_valid_d    = active;
    frame_start_d = (hcount == 11'd0) && (vcount == 10'd0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      bank_q        <= 1'b0;
      addr_q        <= '0;
      word_q        <= '0;
      px_q          <= '0;
      px_valid_q    <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      bank_q        <= bank_d;
      addr_q        <= addr_d;
      word_q        <= word_d;
      px_q          <= px_d;
      px_valid_q    <= px_valid_d;
      frame_start_q <= frame_start_d;
    end
  end

  assign zbtr_read_addr = addr_q;
  assign px_out         = px_q;
  assign px_valid       = px_valid_q;
  assign frame_start    = frame_start_q;

endmodule
